banco_registros_marcador: RTL and testbench
===========================================

Name: banco_registros_marcador

Overview:
Parametrised successor to the single-write MIPS register file, for the pipelined core. It provides two combinational read ports and two synchronous write ports (port A for ALU writeback, port B for load writeback). Same-cycle write-to-read bypass removes the write-then-read hazard. An integrated pending-bit scoreboard lets the hazard unit stall on registers that still have an in-flight producer. All registers clear on reset; there is no file preload.

Parameters:
ANCHO, 32, data width in bits
NUM_REG, 32, number of architectural registers (power of two, ≥2)
DIR_W, $clog2(NUM_REG), register address width (derived, not overridden)
R0_CERO, 1, 1 = register 0 reads as 0, ignores writes, never becomes pending

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs  in  DIR_W  read port 1 address
rt  in  DIR_W  read port 2 address
dr1  out  ANCHO  read port 1 data
dr2  out  ANCHO  read port 2 data
esc_a  in  1  write enable, port A
dir_a  in  DIR_W  write address, port A
dato_a  in  ANCHO  write data, port A
esc_b  in  1  write enable, port B
dir_b  in  DIR_W  write address, port B
dato_b  in  ANCHO  write data, port B
reservar  in  1  issue stage marks dir_res as pending
dir_res  in  DIR_W  destination being reserved
ocupado1  out  1  register rs has an outstanding producer
ocupado2  out  1  register rt has an outstanding producer
num_pend  out  DIR_W+1  count of pending registers

Behaviour:
- Reset (rst_n=0, asynchronous): all registers become 0 and all pending bits become 0. Outputs therefore read dr1=dr2=0, ocupado1=ocupado2=0, num_pend=0. Reset asserted mid-operation wins immediately over any write or reserve. Release is synchronous to the next clk edge.
- Reads are combinational, with zero latency.
- Read priority, for each read port, from highest to lowest:
  - R0_CERO=1 and address is 0 → return 0.
  - esc_b and dir_b matches the address → return dato_b.
  - esc_a and dir_a matches the address → return dato_a.
  - Otherwise → return the stored value.
- Writes commit on the rising edge.
- esc_a and esc_b to the same address in the same cycle: port B (load) wins and dato_a is discarded. The read bypass follows the same priority.
- R0_CERO=1: writes to address 0 are dropped and reservations of address 0 are ignored.
- Pending bit p[i] update on each edge:
  - Set when reservar and dir_res==i.
  - Else cleared when (esc_a and dir_a==i) or (esc_b and dir_b==i).
  - Set has priority over clear: a new producer issued in the same cycle as the old producer's writeback keeps the register pending.
- ocupado1 = p[rs] with a same-cycle clear applied (a writeback to rs this cycle gives 0). A same-cycle reservation is not visible until the next cycle. ocupado2 is the same for rt.
- num_pend is a registered population count of p, updated on the same edge as p. Range is 0..NUM_REG (or 0..NUM_REG-1 when R0_CERO=1).
- A write to a non-pending register is legal: the data commits and p is unchanged. A reserve of an already-pending register is legal: p stays 1 and num_pend is unchanged.
- There are no X on outputs after reset. Out-of-range addresses cannot occur because DIR_W exactly spans NUM_REG.

Decomposition:
- Package banco_pkg holds:
  - default ANCHO and NUM_REG constants
  - a dir_t typedef for register addresses
  - a dato_t typedef for data words
  - the R0 address constant
- Sub-module marcador_ocupado, the scoreboard, contains:
  - the pending vector
  - set/clear priority logic
  - ocupado lookups
  - the num_pend counter
- The top level holds the storage array, write arbitration and read bypass, and instantiates marcador_ocupado.

Test Plan:
- Reset then read all addresses → every dr=0, ocupado=0, num_pend=0. Assert rst_n low mid-cycle after writes → registers immediately 0.
- esc_a with dir_a=5, dato_a=0x1234_5678 while rs=5 in the same cycle → dr1=0x1234_5678 combinationally. Next cycle with esc_a=0 → dr1 still 0x1234_5678.
- esc_a (dir 7, 0xAAAA_AAAA) and esc_b (dir 7, 0x5555_5555) in the same cycle → bypass and stored value are both 0x5555_5555. Write to address 0 with 0xFFFF_FFFF → dr reads 0.
- reservar dir_res=9 → next cycle ocupado1=1 for rs=9 and num_pend=1. Then esc_b to dir 9 → ocupado1=0 in that same cycle, and num_pend=0 on the following cycle.
- Same cycle: reservar dir_res=3 while esc_a to dir 3 clears the old producer → p[3] stays 1 and num_pend is unchanged. reservar dir_res=0 → ignored, num_pend unchanged.
- Parameter sweep ANCHO=16, NUM_REG=8, R0_CERO=0 → address 0 is writable and reservable. Reserve all 8 registers → num_pend=8.

Source files
------------

// File: rtl/banco_pkg.sv
// ----------------------------------------------------------------------------
// banco_pkg
// Shared constants and types for the register file with pending-bit
// scoreboard (banco_registros_marcador) and its scoreboard sub-module.
//   ANCHO_DEF / NUM_REG_DEF : default data width and register count
//   dir_t / dato_t          : register address / data word at default sizes
//   R0_DIR                  : address of the hardwired-zero register
// ----------------------------------------------------------------------------
package banco_pkg;

    localparam int ANCHO_DEF   = 32;
    localparam int NUM_REG_DEF = 32;
    localparam int DIR_W_DEF   = $clog2(NUM_REG_DEF);

    // Register that reads as zero when the R0_CERO parameter is set
    localparam int R0_DIR = 0;

    typedef logic [DIR_W_DEF-1:0] dir_t;
    typedef logic [ANCHO_DEF-1:0] dato_t;

endpackage

// File: rtl/banco_registros_marcador_marcador_ocupado.sv
// ----------------------------------------------------------------------------
// marcador_ocupado
// Pending-bit scoreboard. One bit per architectural register records that an
// issued instruction will still write that register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   rs, rt                : addresses looked up for ocupado1 / ocupado2
//   esc_a/dir_a           : port A writeback (clears the pending bit)
//   esc_b/dir_b           : port B writeback (clears the pending bit)
//   reservar/dir_res      : issue-stage reservation (sets the pending bit)
//   ocupado1, ocupado2    : rs / rt still has an outstanding producer
//   num_pend              : registered population count of the pending bits
// ----------------------------------------------------------------------------
module marcador_ocupado
    import banco_pkg::*;
#(
    parameter  int NUM_REG = NUM_REG_DEF,
    parameter  int R0_CERO = 1,
    localparam int DIR_W   = $clog2(NUM_REG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIR_W-1:0] rs,
    input  logic [DIR_W-1:0] rt,
    input  logic             esc_a,
    input  logic [DIR_W-1:0] dir_a,
    input  logic             esc_b,
    input  logic [DIR_W-1:0] dir_b,
    input  logic             reservar,
    input  logic [DIR_W-1:0] dir_res,
    output logic             ocupado1,
    output logic             ocupado2,
    output logic [DIR_W:0]   num_pend
);

    logic [NUM_REG-1:0] pend;
    logic [NUM_REG-1:0] pend_next;

    // True for the hardwired-zero register, which can never become pending
    function automatic logic es_r0(input logic [DIR_W-1:0] dir);
        return (R0_CERO != 0) && (dir == DIR_W'(R0_DIR));
    endfunction

    // True when either write port commits to dir this cycle
    function automatic logic escribe(input logic [DIR_W-1:0] dir);
        return (esc_a && (dir_a == dir)) || (esc_b && (dir_b == dir));
    endfunction

    function automatic logic [DIR_W:0] contar(input logic [NUM_REG-1:0] v);
        logic [DIR_W:0] n;
        n = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            n = n + (DIR_W+1)'(v[i]);
        end
        return n;
    endfunction

    // A reservation beats a writeback to the same register: the writeback
    // belongs to the previous producer, the reservation to a newer one.
    always_comb begin
        pend_next = pend;
        for (int i = 0; i < NUM_REG; i++) begin
            if (reservar && (dir_res == DIR_W'(i)) && !es_r0(DIR_W'(i))) begin
                pend_next[i] = 1'b1;
            end else if (escribe(DIR_W'(i))) begin
                pend_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            num_pend <= '0;
        end else begin
            pend     <= pend_next;
            num_pend <= contar(pend_next);
        end
    end

    // The value being written back this cycle is already available through
    // the read bypass, so a same-cycle writeback releases the stall. A
    // same-cycle reservation only shows up after the edge.
    always_comb begin
        ocupado1 = pend[rs] && !escribe(rs);
        ocupado2 = pend[rt] && !escribe(rt);
    end

endmodule

// File: rtl/banco_registros_marcador.sv
// ----------------------------------------------------------------------------
// banco_registros_marcador
// Register file for the pipelined core: two combinational read ports with
// same-cycle write bypass, two synchronous write ports (A = ALU writeback,
// B = load writeback, B wins on an address collision) and an integrated
// pending-bit scoreboard for the hazard unit.
//   clk, rst_n                : clock, asynchronous active-low reset
//   rs, rt / dr1, dr2         : read addresses / read data
//   esc_a, dir_a, dato_a      : write port A
//   esc_b, dir_b, dato_b      : write port B
//   reservar, dir_res         : mark dir_res as having an in-flight producer
//   ocupado1, ocupado2        : rs / rt still pending
//   num_pend                  : number of pending registers
// ----------------------------------------------------------------------------
module banco_registros_marcador
    import banco_pkg::*;
#(
    parameter  int ANCHO   = ANCHO_DEF,
    parameter  int NUM_REG = NUM_REG_DEF,
    parameter  int R0_CERO = 1,
    localparam int DIR_W   = $clog2(NUM_REG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIR_W-1:0] rs,
    input  logic [DIR_W-1:0] rt,
    output logic [ANCHO-1:0] dr1,
    output logic [ANCHO-1:0] dr2,
    input  logic             esc_a,
    input  logic [DIR_W-1:0] dir_a,
    input  logic [ANCHO-1:0] dato_a,
    input  logic             esc_b,
    input  logic [DIR_W-1:0] dir_b,
    input  logic [ANCHO-1:0] dato_b,
    input  logic             reservar,
    input  logic [DIR_W-1:0] dir_res,
    output logic             ocupado1,
    output logic             ocupado2,
    output logic [DIR_W:0]   num_pend
);

    logic [ANCHO-1:0] regs [NUM_REG];

    function automatic logic es_r0(input logic [DIR_W-1:0] dir);
        return (R0_CERO != 0) && (dir == DIR_W'(R0_DIR));
    endfunction

    // Read with bypass; port B is checked first so the bypass agrees with
    // the value that will actually be stored on a same-address collision.
    function automatic logic [ANCHO-1:0] leer(input logic [DIR_W-1:0] dir);
        if (es_r0(dir)) begin
            return '0;
        end else if (esc_b && (dir_b == dir)) begin
            return dato_b;
        end else if (esc_a && (dir_a == dir)) begin
            return dato_a;
        end
        return regs[dir];
    endfunction

    // Port B is assigned after port A, so on a collision the load wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (esc_a && !es_r0(dir_a)) begin
                regs[dir_a] <= dato_a;
            end
            if (esc_b && !es_r0(dir_b)) begin
                regs[dir_b] <= dato_b;
            end
        end
    end

    always_comb begin
        dr1 = leer(rs);
        dr2 = leer(rt);
    end

    marcador_ocupado #(
        .NUM_REG (NUM_REG),
        .R0_CERO (R0_CERO)
    ) u_marcador (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs       (rs),
        .rt       (rt),
        .esc_a    (esc_a),
        .dir_a    (dir_a),
        .esc_b    (esc_b),
        .dir_b    (dir_b),
        .reservar (reservar),
        .dir_res  (dir_res),
        .ocupado1 (ocupado1),
        .ocupado2 (ocupado2),
        .num_pend (num_pend)
    );

endmodule

// File: tb/tb_banco_registros_marcador.sv
// ----------------------------------------------------------------------------
// tb_banco_registros_marcador
// Bench for banco_registros_marcador: directed vector table, reset corner
// cases, randomized traffic against a reference model, and a second instance
// with ANCHO=16, NUM_REG=8, R0_CERO=0.
// ----------------------------------------------------------------------------
module tb_banco_registros_marcador;
    import banco_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default-size instance
    dir_t       rs, rt, dir_a, dir_b, dir_res;
    dato_t      dr1, dr2, dato_a, dato_b;
    logic       esc_a, esc_b, reservar, ocupado1, ocupado2;
    logic [5:0] num_pend;

    banco_registros_marcador #(.ANCHO(32), .NUM_REG(32), .R0_CERO(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .dr1(dr1), .dr2(dr2),
        .esc_a(esc_a), .dir_a(dir_a), .dato_a(dato_a),
        .esc_b(esc_b), .dir_b(dir_b), .dato_b(dato_b),
        .reservar(reservar), .dir_res(dir_res),
        .ocupado1(ocupado1), .ocupado2(ocupado2), .num_pend(num_pend)
    );

    // Small instance, register 0 writable
    logic [2:0]  s_rs, s_rt, s_dir_a, s_dir_b, s_dir_res;
    logic [15:0] s_dr1, s_dr2, s_dato_a, s_dato_b;
    logic        s_esc_a, s_esc_b, s_reservar, s_ocupado1, s_ocupado2;
    logic [3:0]  s_num_pend;

    banco_registros_marcador #(.ANCHO(16), .NUM_REG(8), .R0_CERO(0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .rs(s_rs), .rt(s_rt), .dr1(s_dr1), .dr2(s_dr2),
        .esc_a(s_esc_a), .dir_a(s_dir_a), .dato_a(s_dato_a),
        .esc_b(s_esc_b), .dir_b(s_dir_b), .dato_b(s_dato_b),
        .reservar(s_reservar), .dir_res(s_dir_res),
        .ocupado1(s_ocupado1), .ocupado2(s_ocupado2), .num_pend(s_num_pend)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (default-size instance) ----------------
    dato_t m_mem  [32];
    bit    m_pend [32];

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic dato_t m_leer(input dir_t a);
        if (a == 0) return '0;
        if (esc_b && dir_b == a) return dato_b;
        if (esc_a && dir_a == a) return dato_a;
        return m_mem[a];
    endfunction

    function automatic logic m_ocup(input dir_t a);
        return m_pend[a] && !(esc_a && dir_a == a) && !(esc_b && dir_b == a);
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    // What one rising edge does: A then B (B overwrites A), writebacks
    // retire producers, then a new reservation marks its register again.
    task automatic m_edge();
        if (esc_a && dir_a != 0) m_mem[dir_a] = dato_a;
        if (esc_b && dir_b != 0) m_mem[dir_b] = dato_b;
        if (esc_a) m_pend[dir_a] = 1'b0;
        if (esc_b) m_pend[dir_b] = 1'b0;
        if (reservar && dir_res != 0) m_pend[dir_res] = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic ea; dir_t da; dato_t xa;
        logic eb; dir_t db; dato_t xb;
        logic res; dir_t dres;
        dir_t rs; dir_t rt;
        dato_t e1; dato_t e2; logic eo1; logic eo2; int enp;
    } vec_t;

    localparam int NV = 22;
    vec_t tabla [NV];

    task automatic aplicar(input vec_t v);
        esc_a = v.ea; dir_a = v.da; dato_a = v.xa;
        esc_b = v.eb; dir_b = v.db; dato_b = v.xb;
        reservar = v.res; dir_res = v.dres;
        rs = v.rs; rt = v.rt;
    endtask

    task automatic inactivo();
        esc_a = 0; dir_a = '0; dato_a = '0;
        esc_b = 0; dir_b = '0; dato_b = '0;
        reservar = 0; dir_res = '0;
    endtask

    initial begin
        //               ea da xa            eb db xb            rs dr rs rt e1            e2            o1 o2 np
        tabla[0]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 31, 32'h0,        32'h0,        0, 0, 0};
        tabla[1]  = '{1, 5, 32'h12345678, 0, 0, 32'h0,        0, 0, 5, 5,  32'h12345678, 32'h12345678, 0, 0, 0};
        tabla[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 5, 0,  32'h12345678, 32'h0,        0, 0, 0};
        tabla[3]  = '{1, 7, 32'hAAAAAAAA, 1, 7, 32'h55555555, 0, 0, 7, 7,  32'h55555555, 32'h55555555, 0, 0, 0};
        tabla[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 7, 5,  32'h55555555, 32'h12345678, 0, 0, 0};
        tabla[5]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 0, 0, 0,  32'h0,        32'h0,        0, 0, 0};
        tabla[6]  = '{0, 0, 32'h0,        1, 0, 32'hFFFFFFFF, 0, 0, 0, 7,  32'h0,        32'h55555555, 0, 0, 0};
        tabla[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 7,  32'h0,        32'h55555555, 0, 0, 0};
        tabla[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 9, 9, 9,  32'h0,        32'h0,        0, 0, 0};
        tabla[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 9, 9,  32'h0,        32'h0,        1, 1, 1};
        tabla[10] = '{0, 0, 32'h0,        1, 9, 32'hCAFE0009, 0, 0, 9, 5,  32'hCAFE0009, 32'h12345678, 0, 0, 1};
        tabla[11] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 9, 5,  32'hCAFE0009, 32'h12345678, 0, 0, 0};
        tabla[12] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 3, 3, 3,  32'h0,        32'h0,        0, 0, 0};
        tabla[13] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 3, 3,  32'h0,        32'h0,        1, 1, 1};
        tabla[14] = '{1, 3, 32'h33,       0, 0, 32'h0,        1, 3, 3, 3,  32'h33,       32'h33,       0, 0, 1};
        tabla[15] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 3, 3,  32'h33,       32'h33,       1, 1, 1};
        tabla[16] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 3,  32'h0,        32'h33,       0, 1, 1};
        tabla[17] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 3,  32'h0,        32'h33,       0, 1, 1};
        tabla[18] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 3, 3, 3,  32'h33,       32'h33,       1, 1, 1};
        tabla[19] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 3, 3,  32'h33,       32'h33,       1, 1, 1};
        tabla[20] = '{1, 3, 32'h44,       0, 0, 32'h0,        0, 0, 3, 3,  32'h44,       32'h44,       0, 0, 1};
        tabla[21] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 3, 3,  32'h44,       32'h44,       0, 0, 0};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        inactivo(); rs = '0; rt = '0;
        s_rs = '0; s_rt = '0; s_esc_a = 0; s_dir_a = '0; s_dato_a = '0;
        s_esc_b = 0; s_dir_b = '0; s_dato_b = '0; s_reservar = 0; s_dir_res = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 32; a++) begin
            rs = dir_t'(a); rt = dir_t'(31 - a);
            #1;
            chk($sformatf("rst.dr1[%0d]", a), dr1, 0);
            chk($sformatf("rst.dr2[%0d]", a), dr2, 0);
            chk($sformatf("rst.oc1[%0d]", a), ocupado1, 0);
        end
        chk("rst.num_pend", num_pend, 0);
        chk("rst.s_num_pend", s_num_pend, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- vector table ----------------
        for (int k = 0; k < NV; k++) begin
            aplicar(tabla[k]);
            #3;
            chk($sformatf("v%0d.dr1", k), dr1, tabla[k].e1);
            chk($sformatf("v%0d.dr2", k), dr2, tabla[k].e2);
            chk($sformatf("v%0d.oc1", k), ocupado1, tabla[k].eo1);
            chk($sformatf("v%0d.oc2", k), ocupado2, tabla[k].eo2);
            chk($sformatf("v%0d.np", k), num_pend, tabla[k].enp);
            @(posedge clk);
            m_edge();
            #1;
        end

        // ---------------- asynchronous reset mid-cycle ----------------
        inactivo(); reservar = 1; dir_res = 12; rs = 5; rt = 12;
        @(posedge clk); m_edge(); #1;
        inactivo();
        #2;
        chk("pre_rst.dr1", dr1, 32'h12345678);
        chk("pre_rst.oc2", ocupado2, 1);
        chk("pre_rst.np", num_pend, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.dr1", dr1, 0);
        chk("mid_rst.oc2", ocupado2, 0);
        chk("mid_rst.np", num_pend, 0);
        // Writes and reservations during reset have no effect
        esc_a = 1; dir_a = 5; dato_a = 32'h99; reservar = 1; dir_res = 5;
        @(posedge clk); #1;
        inactivo();
        #1;
        chk("in_rst.dr1", dr1, 0);
        chk("in_rst.oc1", ocupado1, 0);
        chk("in_rst.np", num_pend, 0);
        m_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- randomized traffic vs model ----------------
        for (int n = 0; n < 400; n++) begin
            esc_a    = 1'($urandom_range(0, 1));
            esc_b    = 1'($urandom_range(0, 2) == 0);
            reservar = 1'($urandom_range(0, 1));
            dir_a    = dir_t'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            dir_b    = dir_t'($urandom_range(0, 7));
            dir_res  = dir_t'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            rs       = dir_t'($urandom_range(0, 7));
            rt       = dir_t'($urandom_range(0, 31));
            dato_a   = $urandom;
            dato_b   = $urandom;
            #3;
            chk("rnd.dr1", dr1, m_leer(rs));
            chk("rnd.dr2", dr2, m_leer(rt));
            chk("rnd.oc1", ocupado1, m_ocup(rs));
            chk("rnd.oc2", ocupado2, m_ocup(rt));
            chk("rnd.np", num_pend, m_cnt());
            @(posedge clk);
            m_edge();
            #1;
        end
        inactivo();

        // ---------------- ANCHO=16, NUM_REG=8, R0_CERO=0 ----------------
        s_esc_a = 1; s_dir_a = 0; s_dato_a = 16'hBEEF; s_rs = 0; s_rt = 1;
        #3;
        chk("sw.bypass0", s_dr1, 16'hBEEF);
        @(posedge clk); #1;
        s_esc_a = 0;
        #1;
        chk("sw.stored0", s_dr1, 16'hBEEF);
        chk("sw.dr2", s_dr2, 0);
        for (int k = 0; k < 8; k++) begin
            s_reservar = 1; s_dir_res = 3'(k);
            @(posedge clk); #1;
            s_reservar = 0;
            #1;
            chk($sformatf("sw.np%0d", k), s_num_pend, k + 1);
        end
        s_rs = 0; s_rt = 7;
        #1;
        chk("sw.oc1_r0", s_ocupado1, 1);
        chk("sw.oc2_r7", s_ocupado2, 1);
        s_esc_b = 1; s_dir_b = 0; s_dato_b = 16'h1111;
        #1;
        chk("sw.oc1_clr", s_ocupado1, 0);
        chk("sw.oc2_keep", s_ocupado2, 1);
        @(posedge clk); #1;
        s_esc_b = 0;
        #1;
        chk("sw.np_after", s_num_pend, 7);
        chk("sw.dr1_after", s_dr1, 16'h1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
